bcd_convert_arbiter: RTL and testbench
======================================

Name: bcd_convert_arbiter

Overview:
Sequential, shared binary-to-BCD conversion engine for the score display path. It arbitrates round-robin between two requesters, for example the score and the lines/level counters. It runs a one-bit-per-cycle double-dabble conversion on the granted 32-bit value. It returns six BCD digits with a done pulse tagged by requester ID. Values above 999999 saturate to 999999.

Parameters:
WIDTH, 32, binary input width; conversion takes WIDTH shift cycles.
DIGITS, 6, BCD digits returned; internal BCD field is 10 digits (40 bits) to cover the full 32-bit range.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
req0  input  1  requester 0 wants a conversion; level, held until gnt0.
value0  input  WIDTH  requester 0 binary value; sampled only on the grant edge.
req1  input  1  requester 1 request; level, held until gnt1.
value1  input  WIDTH  requester 1 binary value.
gnt0  output  1  one-cycle pulse: value0 captured.
gnt1  output  1  one-cycle pulse: value1 captured.
busy  output  1  high while a conversion is in progress (SHIFT or DONE).
done  output  1  one-cycle pulse: digits/overflow/done_id valid.
done_id  output  1  requester served by this result.
digits  output  4*DIGITS  BCD result; digit 0 (units) in [3:0]; held until the next done.
overflow  output  1  result saturated; held with digits.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - gnt0, gnt1, busy, done, done_id, overflow = 0.
  - digits = 0.
  - Iteration counter = 0.
  - Round-robin pointer last = 1, so req0 wins the first tie.
- Reset asserted mid-conversion aborts it: no done is produced and the captured value is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with any req high, grant one requester. If only one requests, that one wins. If both request, the one not equal to last wins.
  - At that edge: load shift register = {40'd0, value_sel}, counter = 0, remember the ID, set last = ID, pulse gnt_ID for one cycle, busy = 1, go to SHIFT.
  - With no req: stay in IDLE, all pulses 0.
- SHIFT, one iteration per edge:
  - For each of the 10 BCD nibbles: if the nibble ≥ 5, add 3.
  - Then shift the whole {bcd, bin} register left by 1.
  - Counter increments each edge. After the iteration with counter == WIDTH-1, go to DONE. That is exactly WIDTH iterations.
  - Requests are ignored in SHIFT and DONE; a pending req simply waits.
- DONE, single edge:
  - If any of BCD digits 6–9 is nonzero: digits = 0x999999 and overflow = 1.
  - Else: digits = BCD digits 0–5 and overflow = 0.
  - done = 1 for that cycle, done_id = ID, busy = 0, go to IDLE.
- Latency: with the grant at edge N, done is high in the cycle after edge N+WIDTH+1 (edge 33 after the grant for WIDTH=32). The earliest next grant is edge N+WIDTH+2, so throughput is one conversion per 34 cycles.
- Requester rules:
  - Drop req in the cycle after seeing gnt.
  - A req still high when the FSM next returns to IDLE is treated as a new request.
  - value changes after the grant edge have no effect.
- Simultaneous events:
  - Requests arriving during DONE are not granted until IDLE.
  - Back-to-back ties alternate 0, 1, 0, 1.
- Arithmetic: the add-3 is a 4-bit add on a nibble ≤ 9, so the result is ≤ 12 and never carries out of the nibble. The 40-bit BCD field cannot overflow for a 32-bit input.
- No output is combinational from inputs; all outputs are registered.

Test Plan:
1. req0 with value0=0, granted at edge N -> gnt0 in cycle N+1; done at edge N+33 with digits=0x000000, overflow=0, done_id=0; busy high from edge N to N+33.
2. req1 with value1=123456 -> digits=0x123456, done_id=1, overflow=0. Change value1 to 7 on the cycle after gnt1; the result must stay 0x123456.
3. value0=999999 -> digits=0x999999, overflow=0. value0=1000000 -> 0x999999, overflow=1. value0=4294967295 -> 0x999999, overflow=1.
4. req0 and req1 both held high from reset, each dropped after its own gnt and re-raised after its own done:
   - Grant order must be 0, 1, 0, 1.
   - Consecutive grants are 34 cycles apart.
   - The done_ids match the grant order.
   - Each digits value matches its own value.
5. Assert reset at iteration 15 of a conversion of 654321 -> all outputs are 0 immediately and no done appears. After release, a new req1 with value1=42 yields 0x000042.
6. With value0=987654 and req1 asserted during SHIFT -> req1 is not granted until the edge after done; its gnt1 arrives 34 cycles after gnt0.

Source files
------------

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared binary-to-BCD engine (double dabble, one bit per cycle)
// with saturation of results above the displayable digit count.
module bcd_convert_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [WIDTH-1:0]      value0,
    input  logic                  req1,
    input  logic [WIDTH-1:0]      value1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow
);
    localparam int BCDW = 40;
    localparam int SRW  = BCDW + WIDTH;
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_n;
    logic [SRW-1:0]      sr, sr_n, adj;
    logic [CW-1:0]       cnt, cnt_n;
    logic                id, id_n, last, last_n, pick1;
    logic                gnt0_n, gnt1_n, busy_n, done_n, done_id_n, overflow_n;
    logic [4*DIGITS-1:0] digits_n;
    logic [BCDW-4*DIGITS-1:0] hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            id       <= 1'b0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            id       <= id_n;
            last     <= last_n;
            gnt0     <= gnt0_n;
            gnt1     <= gnt1_n;
            busy     <= busy_n;
            done     <= done_n;
            done_id  <= done_id_n;
            digits   <= digits_n;
            overflow <= overflow_n;
        end
    end

    always_comb begin
        adj = sr;
        for (int i = 0; i < BCDW / 4; i++)
            adj[WIDTH+4*i +: 4] = (sr[WIDTH+4*i +: 4] >= 4'd5) ? sr[WIDTH+4*i +: 4] + 4'd3 : sr[WIDTH+4*i +: 4];
        hi         = sr[WIDTH+4*DIGITS +: BCDW-4*DIGITS];
        pick1      = req1 && (!req0 || !last);
        state_n    = state;
        sr_n       = sr;
        cnt_n      = cnt;
        id_n       = id;
        last_n     = last;
        gnt0_n     = 1'b0;
        gnt1_n     = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        done_id_n  = done_id;
        digits_n   = digits;
        overflow_n = overflow;
        case (state)
            IDLE: if (req0 || req1) begin
                state_n = SHIFT;
                sr_n    = {{BCDW{1'b0}}, pick1 ? value1 : value0};
                cnt_n   = '0;
                id_n    = pick1;
                last_n  = pick1;
                gnt0_n  = !pick1;
                gnt1_n  = pick1;
                busy_n  = 1'b1;
            end
            SHIFT: begin
                sr_n    = {adj[SRW-2:0], 1'b0};
                cnt_n   = CW'(cnt + 1'b1);
                state_n = (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                // anything in the upper digits cannot be shown, so pin the display at all nines
                digits_n   = |hi ? {DIGITS{4'h9}} : sr[WIDTH +: 4*DIGITS];
                overflow_n = |hi;
                done_n     = 1'b1;
                done_id_n  = id;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed tests for the shared BCD converter and its arbiter.
module tb_bcd_convert_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] value0 = '0, value1 = '0;
    logic        gnt0, gnt1, busy, done, done_id, overflow;
    logic [23:0] digits;
    int total = 0;
    int bad = 0;

    bcd_convert_arbiter #(.WIDTH(32), .DIGITS(6)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .value0(value0), .req1(req1), .value1(value1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .digits(digits), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Requests one conversion; lat is the count of negedges from the grant sample to the done
    // sample (-1 on timeout), busy_cnt counts busy-high samples before done.
    task automatic run_conv(input bit r, input logic [31:0] v, input logic [31:0] v_after,
                            output int lat, output int busy_cnt);
        bit g = 0;
        lat = -1;
        busy_cnt = 0;
        @(negedge clock);
        if (r) begin value1 = v; req1 = 1'b1; end else begin value0 = v; req0 = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (r ? gnt1 : gnt0) begin g = 1; break; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!g) return;
        if (busy) busy_cnt++;
        if (r) value1 = v_after; else value0 = v_after;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (done) begin lat = i; break; end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        if ({gnt0, gnt1, busy, done, done_id, overflow, digits} !== 30'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {gnt0, gnt1, busy, done, done_id, overflow, digits});
        end
        total++;
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat, bc;
        run_conv(0, 32'd0, 32'd0, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL zero_latency got=%0d want=33", lat); end
        total++;
        if (bc !== 33) begin bad++; $display("FAIL zero_busy got=%0d want=33", bc); end
        total++;
        if ({digits, overflow, done_id, busy} !== {24'h000000, 3'b000}) begin
            bad++; $display("FAIL zero_result got=%h/%b/%b/%b want=000000/0/0/0", digits, overflow, done_id, busy);
        end
        total++;
        @(negedge clock);
        if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
        total++;
    endtask

    task automatic test_value_hold();
        int lat, bc;
        run_conv(1, 32'd123456, 32'd7, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL hold_latency got=%0d want=33", lat); end
        total++;
        if ({digits, overflow, done_id} !== {24'h123456, 2'b01}) begin
            bad++; $display("FAIL hold_result got=%h/%b/%b want=123456/0/1", digits, overflow, done_id);
        end
        total++;
    endtask

    task automatic test_saturate();
        logic [31:0] vals [3] = '{32'd999999, 32'd1000000, 32'hFFFF_FFFF};
        logic        ovfs [3] = '{1'b0, 1'b1, 1'b1};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_conv(0, vals[i], vals[i], lat, bc);
            if (lat !== 33 || digits !== 24'h999999 || overflow !== ovfs[i]) begin
                bad++; $display("FAIL saturate_%0d got=lat%0d/%h/%b want=lat33/999999/%b", i, lat, digits, overflow, ovfs[i]);
            end
            total++;
        end
    endtask

    task automatic test_back_to_back();
        int gt [4], gid [4], did [4];
        logic [23:0] dd [4];
        int ng = 0, nd = 0, g0 = 0, g1 = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        value0 = 32'd111111;
        value1 = 32'd222222;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int t = 0; t < 300 && nd < 4; t++) begin
            @(negedge clock);
            if (gnt0 && ng < 4) begin gt[ng] = t; gid[ng] = 0; ng++; g0++; req0 = 1'b0; end
            if (gnt1 && ng < 4) begin gt[ng] = t; gid[ng] = 1; ng++; g1++; req1 = 1'b0; end
            if (done) begin
                did[nd] = int'(done_id); dd[nd] = digits; nd++;
                if (!done_id && g0 < 2) req0 = 1'b1;
                if (done_id && g1 < 2) req1 = 1'b1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (nd !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nd); end
        total++;
        for (int i = 0; i < 4 && i < nd; i++) begin
            if (gid[i] !== (i % 2) || did[i] !== (i % 2) || dd[i] !== ((i % 2) ? 24'h222222 : 24'h111111)) begin
                bad++; $display("FAIL b2b_order_%0d got=g%0d/d%0d/%h want=%0d/%0d/%h", i, gid[i], did[i], dd[i],
                                i % 2, i % 2, (i % 2) ? 24'h222222 : 24'h111111);
            end
            total++;
            if (i > 0 && gt[i] - gt[i-1] !== 34) begin
                bad++; $display("FAIL b2b_spacing_%0d got=%0d want=34", i, gt[i] - gt[i-1]);
            end
            if (i > 0) total++;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_abort();
        int lat, bc, seen = 0;
        bit g = 0;
        @(negedge clock);
        value0 = 32'd654321;
        req0 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (gnt0) begin g = 1; break; end
        end
        req0 = 1'b0;
        if (!g) begin bad++; $display("FAIL abort_grant got=0 want=1"); end
        total++;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        #1;
        if ({gnt0, gnt1, busy, done, done_id, overflow, digits} !== 30'd0) begin
            bad++; $display("FAIL abort_outputs got=%h want=0", {gnt0, gnt1, busy, done, done_id, overflow, digits});
        end
        total++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
        total++;
        run_conv(1, 32'd42, 32'd42, lat, bc);
        if (lat !== 33 || {digits, overflow, done_id} !== {24'h000042, 2'b01}) begin
            bad++; $display("FAIL abort_recover got=lat%0d/%h/%b/%b want=lat33/000042/0/1", lat, digits, overflow, done_id);
        end
        total++;
    endtask

    task automatic test_pending_req();
        int done_k = -1, gnt1_k = -1, lat;
        logic [23:0] d0 = '0;
        bit g = 0;
        @(negedge clock);
        value0 = 32'd987654;
        req0 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (gnt0) begin g = 1; break; end
        end
        req0 = 1'b0;
        if (!g) begin bad++; $display("FAIL pend_grant0 got=0 want=1"); end
        total++;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 5) begin value1 = 32'd5; req1 = 1'b1; end
            if (done && done_k < 0) begin done_k = k; d0 = digits; end
            if (gnt1) begin gnt1_k = k; break; end
        end
        req1 = 1'b0;
        if (done_k !== 33 || d0 !== 24'h987654) begin
            bad++; $display("FAIL pend_first got=k%0d/%h want=k33/987654", done_k, d0);
        end
        total++;
        if (gnt1_k !== 34) begin bad++; $display("FAIL pend_gnt1_time got=%0d want=34", gnt1_k); end
        total++;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (done) begin lat = i; break; end
        end
        if (lat !== 33 || {digits, overflow, done_id} !== {24'h000005, 2'b01}) begin
            bad++; $display("FAIL pend_second got=lat%0d/%h/%b/%b want=lat33/000005/0/1", lat, digits, overflow, done_id);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_value_hold();
        test_saturate();
        test_back_to_back();
        test_abort();
        test_pending_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
